// File: rtl/display_scan_ctrl_if.sv
// Bundle of scan-controller signals: the controlling side (master) drives strobes,
// data and the digit mask; the scan controller (slave) returns the registered display outputs.
interface display_scan_ctrl_if;
   logic        tick;
   logic        load;
   logic [31:0] data_in;
   logic [7:0]  digit_en;
   logic [7:0]  anodes;
   logic [3:0]  hex_out;
   logic [2:0]  digit_sel;
   logic        upd_pending;

   modport master (
      output tick, load, data_in, digit_en,
      input  anodes, hex_out, digit_sel, upd_pending
   );

   modport slave (
      input  tick, load, data_in, digit_en,
      output anodes, hex_out, digit_sel, upd_pending
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller with blanking gap and frame-synchronous data commit.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits (digit 0 always shown).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_SHOW  | current digit driven (if enabled); tick starts the blank gap
// ST_BLANK | all anodes off for BLANK_CYCLES cycles, then advance digit
module display_scan_ctrl #(
   parameter int unsigned BLANK_CYCLES = 4
) (
   input  logic                clk100mhz,
   input  logic                reset,
   display_scan_ctrl_if.slave  bus
);

   localparam logic [0:0] ST_SHOW  = 1'b0;
   localparam logic [0:0] ST_BLANK = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [7:0]  blank_cnt_q, blank_cnt_d;
   logic [2:0]  sel_q, sel_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] disp_q, disp_d;
   logic        pend_q, pend_d;
   logic [7:0]  anodes_q, anodes_d;
   logic [3:0]  hex_q, hex_d;
   logic [2:0]  dsel_q;

   logic [2:0]  next_idx;
   logic [2:0]  cand;
   logic        found;
   logic        boundary;
   logic        suppress;

   // First enabled index after sel_q going upward with wrap; k=8 lands back on sel_q.
   always_comb begin
      next_idx = sel_q;
      cand     = sel_q;
      found    = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cand = sel_q + 3'(k);
         if (!found && bus.digit_en[cand]) begin
            next_idx = cand;
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      blank_cnt_d = blank_cnt_q;
      sel_d       = sel_q;
      boundary    = 1'b0;
      case (state_q)
         ST_SHOW: begin
            if (bus.tick) begin
               state_d     = ST_BLANK;
               blank_cnt_d = 8'(BLANK_CYCLES - 1);
            end
         end
         default: begin
            if (blank_cnt_q == 8'd0) begin
               state_d  = ST_SHOW;
               sel_d    = next_idx;
               boundary = (next_idx <= sel_q);
            end else begin
               blank_cnt_d = blank_cnt_q - 8'd1;
            end
         end
      endcase
      if (bus.tick && (bus.digit_en == 8'h00)) begin
         boundary = 1'b1;
      end
   end

   // A load on the boundary edge wins over the commit, pushing the commit to the next frame.
   always_comb begin
      shadow_d = shadow_q;
      disp_d   = disp_q;
      pend_d   = pend_q;
      if (bus.load) begin
         shadow_d = bus.data_in;
         pend_d   = 1'b1;
      end else if (boundary && pend_q) begin
         disp_d = shadow_q;
         pend_d = 1'b0;
      end
   end

   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      suppress = (sel_q != 3'd0) && ((disp_q >> {sel_q, 2'b00}) == 32'h0);
`else
      suppress = 1'b0;
`endif
      anodes_d = 8'hFF;
      if ((state_q == ST_SHOW) && bus.digit_en[sel_q] && !suppress) begin
         anodes_d = ~(8'b1 << sel_q);
      end
      hex_d = disp_q[{sel_q, 2'b00} +: 4];
   end

   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         state_q     <= ST_SHOW;
         blank_cnt_q <= 8'd0;
         sel_q       <= 3'd0;
         shadow_q    <= 32'h0;
         disp_q      <= 32'h0;
         pend_q      <= 1'b0;
         anodes_q    <= 8'hFF;
         hex_q       <= 4'h0;
         dsel_q      <= 3'd0;
      end else begin
         state_q     <= state_d;
         blank_cnt_q <= blank_cnt_d;
         sel_q       <= sel_d;
         shadow_q    <= shadow_d;
         disp_q      <= disp_d;
         pend_q      <= pend_d;
         anodes_q    <= anodes_d;
         hex_q       <= hex_d;
         dsel_q      <= sel_q;
      end
   end

   assign bus.anodes      = anodes_q;
   assign bus.hex_out     = hex_q;
   assign bus.digit_sel   = dsel_q;
   assign bus.upd_pending = pend_q;

endmodule
